// File: rtl/calc_display_rx_if.sv
// rtl/calc_display_rx_if.sv - display-scan link bundle (status/pos/data) from calculator to display receiver
// Ports: status[1:0] link status, pos[3:0] digit position, data[3:0] BCD value.
// master drives the link (calculator side), slave samples it (display receiver).
interface calc_display_rx_if;
    logic [1:0] status;
    logic [3:0] pos;
    logic [3:0] data;

    modport master (output status, pos, data);
    modport slave  (input  status, pos, data);
endinterface

// File: rtl/calc_display_rx.sv
// rtl/calc_display_rx.sv - display-scan receiver: frame assembly, atomic commit, 8-digit 7-segment scan
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-low reset
//   link        slave side of the status/pos/data scan link
//   an[7:0]     one-hot digit enables (polarity per ACTIVE_LOW)
//   seg[6:0]    segments {g,f,e,d,c,b,a} of the enabled digit
//   dp          decimal point, held off
//   frame_done  one-cycle pulse when a complete frame is committed
//   frame_drop  one-cycle pulse when a partial frame is discarded
//   err         committed frame was received with error status
module calc_display_rx #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    calc_display_rx_if.slave   link,
    output logic [7:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               frame_done,
    output logic               frame_drop,
    output logic               err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [7:0][3:0] shadow;
    logic [7:0][3:0] disp;
    logic [7:0][3:0] frame_next;
    logic [7:0]      mask;
    logic            shadow_err;
    logic [PW-1:0]   prescale;
    logic [2:0]      scan_idx;

    logic            beat_ok;
    logic            last_beat;
    logic            commit;
    logic            drop;
    logic [7:0]      lead_zero;
    logic [3:0]      digit;
    logic [6:0]      seg_c;

    // Status 00 (error) and 01 (busy) both carry digits; pos[3] set means out of range.
    assign beat_ok   = (link.status == 2'b00 || link.status == 2'b01) && !link.pos[3];
    assign last_beat = beat_ok && (link.pos[2:0] == 3'd7);
    assign commit    = last_beat && (&mask[6:0]);
    assign drop      = (last_beat && !(&mask[6:0])) || (link.status == 2'b10 && |mask);

    // The committed frame includes the pos-7 beat arriving this cycle.
    always_comb begin
        frame_next    = shadow;
        frame_next[7] = link.data;
    end

    // lead_zero[k]: digit k and every digit above it hold 0.
    always_comb begin
        lead_zero    = '0;
        lead_zero[7] = (disp[7] == 4'd0);
        for (int k = 6; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (disp[k] == 4'd0);
        end
    end

    assign digit = disp[scan_idx];

    always_comb begin
        seg_c = 7'h00;
        if (err) begin
            seg_c = 7'h40;
        end else if (!(BLANK_LZ && scan_idx != 3'd0 && lead_zero[scan_idx])) begin
            case (digit)
                4'd0:    seg_c = 7'h3F;
                4'd1:    seg_c = 7'h06;
                4'd2:    seg_c = 7'h5B;
                4'd3:    seg_c = 7'h4F;
                4'd4:    seg_c = 7'h66;
                4'd5:    seg_c = 7'h6D;
                4'd6:    seg_c = 7'h7D;
                4'd7:    seg_c = 7'h07;
                4'd8:    seg_c = 7'h7F;
                4'd9:    seg_c = 7'h6F;
                default: seg_c = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow     <= '0;
            disp       <= '0;
            mask       <= '0;
            shadow_err <= 1'b0;
            prescale   <= '0;
            scan_idx   <= 3'd0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            an         <= {8{ACTIVE_LOW}};
            seg        <= {7{ACTIVE_LOW}};
            dp         <= ACTIVE_LOW;
        end else begin
            frame_done <= commit;
            frame_drop <= drop;

            if (commit) begin
                disp       <= frame_next;
                err        <= shadow_err || (link.status == 2'b00);
                mask       <= '0;
                shadow_err <= 1'b0;
            end else if (drop) begin
                mask       <= '0;
                shadow_err <= 1'b0;
            end else if (beat_ok) begin
                shadow[link.pos[2:0]] <= link.data;
                mask[link.pos[2:0]]   <= 1'b1;
                if (link.status == 2'b00) begin
                    shadow_err <= 1'b1;
                end
            end

            if (prescale == PW'(REFRESH_DIV - 1)) begin
                prescale <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end

            // Outputs follow the scan index and buffer as they stood before this edge.
            an  <= ACTIVE_LOW ? ~(8'd1 << scan_idx) : (8'd1 << scan_idx);
            seg <= ACTIVE_LOW ? ~seg_c : seg_c;
            dp  <= ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_calc_display_rx.sv
// tb/tb_calc_display_rx.sv - self-checking bench for calc_display_rx against a frame-level reference model
module tb_calc_display_rx;

    localparam int DIV = 4;
    localparam logic [6:0] FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    calc_display_rx_if link ();

    logic [7:0] an;
    logic [6:0] seg;
    logic       dp, frame_done, frame_drop, err;

    calc_display_rx #(
        .REFRESH_DIV(DIV),
        .BLANK_LZ   (1'b1),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .link      (link),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done),
        .frame_drop(frame_drop),
        .err       (err)
    );

    wire  [18:0] obs = {an, seg, dp, frame_done, frame_drop, err};
    logic [18:0] expv;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the frame being collected, the frame on display, and
    // the number of edges since reset release (scan position is derived from it).
    logic [3:0] m_shadow [8];
    bit         m_wr     [8];
    bit         m_serr;
    logic [3:0] m_disp   [8];
    bit         m_err;
    int         m_k;

    function automatic logic [6:0] seg_of(input int idx);
        logic [6:0] s;
        bit allz;
        allz = 1'b1;
        for (int j = idx; j < 8; j++) if (m_disp[j] != 4'd0) allz = 1'b0;
        if (m_err)                 s = 7'h40;
        else if (idx > 0 && allz)  s = 7'h00;
        else if (m_disp[idx] > 9)  s = 7'h00;
        else                       s = FONT[m_disp[idx]];
        return ~s;
    endfunction

    task automatic apply(input bit rn, input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        bit valid, full, anyw, cm, dr, e;
        int idx;
        reset       = rn;
        link.status = st;
        link.pos    = p;
        link.data   = d;
        valid = (st == 2'b00 || st == 2'b01) && (p < 8);
        full  = 1'b1;
        anyw  = 1'b0;
        for (int j = 0; j < 7; j++) if (!m_wr[j]) full = 1'b0;
        for (int j = 0; j < 8; j++) if (m_wr[j]) anyw = 1'b1;
        cm = rn && valid && (p == 7) && full;
        dr = rn && ((valid && (p == 7) && !full) || (st == 2'b10 && anyw));
        if (!rn) begin
            expv = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
        end else begin
            idx  = (m_k / DIV) % 8;
            e    = cm ? (m_serr || st == 2'b00) : m_err;
            expv = {~(8'd1 << idx), seg_of(idx), 1'b1, cm, dr, e};
        end
        @(posedge clock);
        #1;
        if (!rn) begin
            m_k = 0; m_serr = 0; m_err = 0;
            for (int j = 0; j < 8; j++) begin m_wr[j] = 0; m_shadow[j] = 0; m_disp[j] = 0; end
        end else begin
            m_k++;
            if (cm) begin
                for (int j = 0; j < 7; j++) m_disp[j] = m_shadow[j];
                m_disp[7] = d;
                m_err = m_serr || (st == 2'b00);
                m_serr = 0;
                for (int j = 0; j < 8; j++) m_wr[j] = 0;
            end else if (dr) begin
                m_serr = 0;
                for (int j = 0; j < 8; j++) m_wr[j] = 0;
            end else if (valid) begin
                m_shadow[p[2:0]] = d;
                m_wr[p[2:0]] = 1;
                if (st == 2'b00) m_serr = 1;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'b01, 4'(i), 4'd5);
            n_vec++;
            if (obs !== 19'h7FFF8 || obs !== expv) begin
                n_bad++;
                $display("FAIL reset %0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_scan();
        int hot;
        for (int i = 0; i < 8 * DIV + 6; i++) begin
            apply(1'b1, 2'b10, 4'd0, 4'd0);
            n_vec++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL scan cycle %0d: got %h want %h", i, obs, expv);
            end
            hot = 0;
            for (int b = 0; b < 8; b++) if (!an[b]) hot++;
            n_vec++;
            if (hot !== 1) begin
                n_bad++;
                $display("FAIL scan onehot cycle %0d: got an=%h want one active bit", i, an);
            end
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b01, 4'(i), 4'(7 - i));
            n_vec++;
            if (obs !== expv || frame_done !== (i == 7)) begin
                n_bad++;
                $display("FAIL frame beat %0d: got %h want %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 8 * DIV; i++) begin
            apply(1'b1, 2'b10, 4'd0, 4'd0);
            n_vec++;
            if (obs !== expv || frame_done !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL frame show %0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_drop_on_ready();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 2'b01, 4'(i), 4'd9);
            n_vec++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL drop beat %0d: got %h want %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 2 * DIV + 8; i++) begin
            apply(1'b1, 2'b10, 4'd0, 4'd0);
            n_vec++;
            if (obs !== expv || frame_drop !== (i == 0) || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL drop idle %0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_err_then_12();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b00, 4'(i), 4'(i));
            n_vec++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL errframe beat %0d: got %h want %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 8 * DIV; i++) begin
            apply(1'b1, 2'b11, 4'd0, 4'd0);
            n_vec++;
            if (obs !== expv || err !== 1'b1) begin
                n_bad++;
                $display("FAIL errframe show %0d: got %h want %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b01, 4'(i), (i == 0) ? 4'd2 : (i == 1) ? 4'd1 : 4'd0);
            n_vec++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL twelve beat %0d: got %h want %h", i, obs, expv);
            end
        end
        for (int i = 0; i < 8 * DIV + 1; i++) begin
            apply(1'b1, 2'b10, 4'd0, 4'd0);
            n_vec++;
            if (obs !== expv || err !== 1'b0) begin
                n_bad++;
                $display("FAIL twelve show %0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 7; i++) apply(1'b1, 2'b01, 4'(i), 4'(i + 1));
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) apply(1'b1, 2'b01, 4'(8 + (i % 8)), 4'd5);
            else            apply(1'b1, 2'b11, 4'd7, 4'd5);
            n_vec++;
            if (obs !== expv || frame_done !== 1'b0 || frame_drop !== 1'b0) begin
                n_bad++;
                $display("FAIL ignored %0d: got %h want %h", i, obs, expv);
            end
        end
        apply(1'b1, 2'b01, 4'd7, 4'd3);
        n_vec++;
        if (obs !== expv || frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL ignored commit: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) apply(1'b1, 2'b01, 4'(i), 4'd8);
        apply(1'b0, 2'b01, 4'd4, 4'd8);
        n_vec++;
        if (obs !== 19'h7FFF8) begin
            n_bad++;
            $display("FAIL midreset outputs: got %h want %h", obs, 19'h7FFF8);
        end
        for (int i = 4; i < 8; i++) begin
            apply(1'b1, 2'b01, 4'(i), 4'd8);
            n_vec++;
            if (obs !== expv || frame_drop !== (i == 7) || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset beat %0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int order [7];
        int mode, t;
        for (int it = 0; it < 250; it++) begin
            mode = $urandom_range(0, 9);
            if (mode < 5) begin
                for (int j = 0; j < 7; j++) order[j] = j;
                for (int j = 6; j > 0; j--) begin
                    int r;
                    r = $urandom_range(0, j);
                    t = order[j]; order[j] = order[r]; order[r] = t;
                end
                for (int j = 0; j < 8; j++) begin
                    if ($urandom_range(0, 3) == 0)
                        apply(1'b1, 2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                    else if ($urandom_range(0, 7) == 0)
                        apply(1'b1, 2'($urandom_range(0, 1)), 4'($urandom_range(8, 15)), 4'($urandom_range(0, 15)));
                    else
                        apply(1'b1, ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01,
                              (j < 7) ? 4'(order[j]) : 4'd7, 4'($urandom_range(0, 11)));
                    n_vec++;
                    if (obs !== expv) begin
                        n_bad++;
                        $display("FAIL random frame it %0d beat %0d: got %h want %h", it, j, obs, expv);
                    end
                end
            end else if (mode < 8) begin
                apply(($urandom_range(0, 40) != 0), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                n_vec++;
                if (obs !== expv) begin
                    n_bad++;
                    $display("FAIL random beat it %0d: got %h want %h", it, obs, expv);
                end
            end else begin
                for (int j = 0; j < DIV * 3; j++) begin
                    apply(1'b1, 2'b10, 4'd0, 4'd0);
                    n_vec++;
                    if (obs !== expv) begin
                        n_bad++;
                        $display("FAIL random idle it %0d: got %h want %h", it, obs, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        m_k = 0; m_serr = 0; m_err = 0;
        for (int j = 0; j < 8; j++) begin m_wr[j] = 0; m_shadow[j] = 0; m_disp[j] = 0; end
        test_reset();
        test_scan();
        test_frame();
        test_drop_on_ready();
        test_err_then_12();
        test_ignored();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
